// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver:
// glyph table, segment bit positions and all-on/all-off helpers.
package seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g,f,e,d,c,b,a}, entry 0 at the right.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] seg_all_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] seg_all_on(input bit active_low);
        return active_low ? 8'h00 : 8'hFF;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Hex nibble to active-high seven-segment pattern lookup.
// Bit order of the result is {g,f,e,d,c,b,a}.
module seven_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with
// frame-synchronous update, blank guard and leading-zero blanking.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;

    logic [DW-1:0]         pend_data;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] pend_en;
    logic                  pend_valid;

    logic [DW-1:0]         disp_data;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [NUM_DIGITS-1:0] disp_en;
    logic                  lz_shadow;

    logic                  slot_end;
    logic                  frame_end;
    logic                  guard;

    logic [3:0]            sel_nibble;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] dig_on;
    logic [6:0]            glyph;
    logic [7:0]            seg_lit;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    if (BLANK_CYCLES > 0) begin : g_guard
        assign guard = (cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_guard
        assign guard = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Display enables come out of reset set so a cleared display reads "0".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_en    <= '1;
            lz_shadow  <= 1'b0;
        end else if (frame_end) begin
            pend_valid <= 1'b0;
            if (load) begin
                disp_data <= data_in;
                disp_dp   <= dp_in;
                disp_en   <= digit_en;
                lz_shadow <= lz_blank;
            end else if (pend_valid) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                disp_en   <= pend_en;
                lz_shadow <= lz_blank;
            end
        end else if (load) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_en    <= digit_en;
            pend_valid <= 1'b1;
        end
    end

    // Walk from the top digit down so each digit knows if all above are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_data[4*k +: 4] == 4'h0);
            blank[k]   = !disp_en[k] || (lz_shadow && upper_zero && (k != 0));
        end
    end

    always_comb begin
        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b1;
        dig_on     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_nibble = disp_data[4*k +: 4];
                sel_dp     = disp_dp[k];
                sel_blank  = blank[k];
                dig_on[k]  = 1'b1;
            end
        end
    end

    seven_seg_glyph u_glyph (
        .nibble (sel_nibble),
        .glyph  (glyph)
    );

    always_comb begin
        seg_lit = '0;
        if (!sel_blank) begin
            seg_lit[SEG_G:SEG_A] = glyph;
            seg_lit[SEG_DP]      = sel_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= seg_all_off(SEG_ACTIVE_LOW);
            dig_sel    <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (guard) begin
                seg_out <= seg_all_off(SEG_ACTIVE_LOW);
                dig_sel <= DIG_OFF;
            end else begin
                seg_out <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
                dig_sel <= DIG_ACTIVE_LOW ? ~dig_on : dig_on;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomised self-checking bench for seven_seg_scan_driver against a
// time-indexed reference model of the scan and frame-update rules.
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (N),
        .CLK_DIV        (DIV),
        .BLANK_CYCLES   (BLK),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .lz_blank   (lz_blank),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int t      = 0;

    // Model state: what is on display and what is queued.
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, m_en, p_dp, p_en;
    bit          m_lz, p_valid;

    logic [7:0] exp_seg;
    logic [3:0] exp_dig;
    logic       exp_fd;

    logic [6:0] glyph_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic void model_reset();
        m_val   = '0;
        m_dp    = '0;
        m_en    = 4'hF;
        m_lz    = 1'b0;
        p_val   = '0;
        p_dp    = '0;
        p_en    = '0;
        p_valid = 1'b0;
        t       = 0;
    endfunction

    // Expected outputs after the edge taken at time position pos.
    function automatic void expect_at(int pos);
        int  slot, d, nib;
        bit  blank;
        slot   = pos % DIV;
        d      = (pos / DIV) % N;
        exp_fd = ((pos % FRAME) == FRAME - 1);
        if (slot < BLK) begin
            exp_seg = 8'hFF;
            exp_dig = 4'hF;
        end else begin
            exp_dig = ~(4'(1) << d);
            nib     = int'((m_val >> (4 * d)) & 16'hF);
            blank   = !m_en[d] || (m_lz && d != 0 && (m_val >> (4 * d)) == 0);
            exp_seg = blank ? 8'hFF : ~{m_dp[d], glyph_tab[nib]};
        end
    endfunction

    task automatic advance(input bit ld);
        bit fend;
        load = ld;
        expect_at(t);
        fend = ((t % FRAME) == FRAME - 1);
        if (fend) begin
            if (ld) begin
                m_val = data_in; m_dp = dp_in; m_en = digit_en; m_lz = lz_blank;
            end else if (p_valid) begin
                m_val = p_val; m_dp = p_dp; m_en = p_en; m_lz = lz_blank;
            end
            p_valid = 1'b0;
        end else if (ld) begin
            p_val = data_in; p_dp = dp_in; p_en = digit_en; p_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        t++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({seg_out, dig_sel, frame_done} !== {8'hFF, 4'hF, 1'b0})
            $display("FAIL reset_hold seg=%h dig=%h fd=%b want seg=ff dig=f fd=0",
                     seg_out, dig_sel, frame_done);
        else n_pass++;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            advance(1'b0);
            n_chk++;
            if ({seg_out, dig_sel, frame_done} !== {exp_seg, exp_dig, exp_fd})
                $display("FAIL reset_scan t=%0d seg=%h dig=%h fd=%b want %h %h %b",
                         t, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
            else n_pass++;
        end
    endtask

    task automatic test_load_midframe();
        while ((t % FRAME) != 10) advance(1'b0);
        data_in = 16'h12AF; dp_in = 4'b0010; digit_en = 4'hF; lz_blank = 1'b0;
        advance(1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance(1'b0);
            n_chk++;
            if ({seg_out, dig_sel, frame_done} !== {exp_seg, exp_dig, exp_fd})
                $display("FAIL load_midframe t=%0d seg=%h dig=%h fd=%b want %h %h %b",
                         t, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
            else n_pass++;
        end
        // Digit 0 slot of a settled frame: F with dp off.
        while ((t % FRAME) != 4) advance(1'b0);
        n_chk++;
        if ({seg_out, dig_sel} !== {8'h8E, 4'b1110})
            $display("FAIL digit0_F seg=%h dig=%h want 8e e", seg_out, dig_sel);
        else n_pass++;
        while ((t % FRAME) != DIV + 4) advance(1'b0);
        n_chk++;
        if ({seg_out, dig_sel} !== {8'h08, 4'b1101})
            $display("FAIL digit1_Adp seg=%h dig=%h want 08 d", seg_out, dig_sel);
        else n_pass++;
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [2] = '{16'h0070, 16'h0000};
        foreach (vals[v]) begin
            data_in = vals[v]; dp_in = '0; digit_en = 4'hF; lz_blank = 1'b1;
            advance(1'b1);
            for (int i = 0; i < 2 * FRAME; i++) begin
                advance(1'b0);
                n_chk++;
                if ({seg_out, dig_sel, frame_done} !== {exp_seg, exp_dig, exp_fd})
                    $display("FAIL lz_blank v=%h t=%0d seg=%h dig=%h want %h %h",
                             vals[v], t, seg_out, dig_sel, exp_seg, exp_dig);
                else n_pass++;
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_load_at_frame_end();
        while ((t % FRAME) != FRAME - 1) advance(1'b0);
        data_in = 16'h9999; dp_in = '0; digit_en = 4'hF;
        advance(1'b1);
        for (int i = 0; i < FRAME; i++) begin
            advance(1'b0);
            n_chk++;
            if ({seg_out, dig_sel, frame_done} !== {exp_seg, exp_dig, exp_fd})
                $display("FAIL load_frame_end t=%0d seg=%h dig=%h want %h %h",
                         t, seg_out, dig_sel, exp_seg, exp_dig);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        while ((t % FRAME) != 3) advance(1'b0);
        data_in = 16'h1111;
        advance(1'b1);
        advance(1'b0);
        data_in = 16'h2222; digit_en = 4'b1011;
        advance(1'b1);
        data_in = 16'h3333;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance(1'b0);
            n_chk++;
            if ({seg_out, dig_sel, frame_done} !== {exp_seg, exp_dig, exp_fd})
                $display("FAIL back_to_back t=%0d seg=%h dig=%h want %h %h",
                         t, seg_out, dig_sel, exp_seg, exp_dig);
            else n_pass++;
        end
        while ((t % FRAME) != 2 * DIV + 5) advance(1'b0);
        n_chk++;
        if ({seg_out, dig_sel} !== {8'hFF, 4'b1011})
            $display("FAIL digit2_disabled seg=%h dig=%h want ff b", seg_out, dig_sel);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 10 * FRAME; i++) begin
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00FF;
            if ($urandom_range(0, 7) == 0) lz_blank = ~lz_blank;
            advance($urandom_range(0, 11) == 0);
            n_chk++;
            if ({seg_out, dig_sel, frame_done} !== {exp_seg, exp_dig, exp_fd})
                $display("FAIL random t=%0d seg=%h dig=%h fd=%b want %h %h %b",
                         t, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midscan();
        data_in = 16'hBEEF; dp_in = 4'hF; digit_en = 4'hF; lz_blank = 1'b0;
        advance(1'b1);
        while ((t % FRAME) != 2 * DIV + 5) advance(1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({seg_out, dig_sel, frame_done} !== {8'hFF, 4'hF, 1'b0})
            $display("FAIL async_reset seg=%h dig=%h fd=%b want ff f 0",
                     seg_out, dig_sel, frame_done);
        else n_pass++;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            advance(1'b0);
            n_chk++;
            if ({seg_out, dig_sel, frame_done} !== {exp_seg, exp_dig, exp_fd})
                $display("FAIL after_reset t=%0d seg=%h dig=%h fd=%b want %h %h %b",
                         t, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_lz_blank();
        test_load_at_frame_end();
        test_back_to_back();
        test_random();
        test_reset_midscan();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
